burst_mem_responder: RTL
========================

Name: burst_mem_responder

Overview:
- Memory-side responder for the cacheline burst protocol; the physical-memory end of the cacheline adaptor link.
- Accepts one line-sized read or write request from the controller and, after a programmable access latency, streams BURST_LEN 32-bit beats with mem_resp held high.
- Backed by an internal line-organised array. Used as the synthesizable pmem stand-in for core/cache bring-up and as the DUT-side model in cache benches.

Parameters:
- ADDR_WIDTH, 32, width of mem_address.
- DEPTH_LINES, 256, number of lines stored; power of two.
- BURST_LEN, 8, beats per line (8 x 32 = 256-bit line); power of two, >= 2.
- LATENCY, 4, cycles from request acceptance to first beat; >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_address  input  ADDR_WIDTH  line address from controller; low log2(BURST_LEN*4) bits ignored.
- mem_read  input  1  read request.
- mem_write  input  1  write request.
- mem_wdata  input  32  write beat data.
- mem_byte_enable  input  4  per-byte write mask for the current beat.
- mem_rdata  output  32  read beat data.
- mem_resp  output  1  high exactly for each of the BURST_LEN beat cycles.
- busy  output  1  high whenever state != IDLE.
- err  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset: mem_resp=0, mem_rdata=0, busy=0, err=0, state=IDLE, wait/beat counters=0. Array contents are not reset.
- Reset asserted mid-operation aborts the transaction; mem_resp=0 from the next edge. Beats already written stay written.
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - mem_read or mem_write sampled high at an edge: latch op, line index and direction; go to WAIT with wait count = LATENCY-1.
  - Both high: read wins; write is ignored.
- WAIT:
  - Count down, mem_resp=0. Goes to BURST so that the first mem_resp=1 cycle is exactly LATENCY cycles after the accept edge.
  - Address and request lines are not re-sampled.
- BURST:
  - mem_resp=1 for BURST_LEN consecutive cycles; beat counter k = 0..BURST_LEN-1.
  - Read: mem_rdata = mem[line][k] in the same cycle as mem_resp.
  - Write: at each edge with mem_resp=1, mem[line][k] byte b <= mem_wdata byte b where mem_byte_enable[b]=1; masked bytes are unchanged.
  - After beat BURST_LEN-1, go to DONE.
- DONE:
  - One cycle with mem_resp=0 so the controller sees resp fall as end-of-burst.
  - Requests are ignored; return to IDLE.
  - Minimum request-to-request spacing = LATENCY + BURST_LEN + 2 cycles.
- Controller contract: hold mem_read/mem_write high until the first beat. Present write beat k during the k-th mem_resp cycle.
- Addressing:
  - line = mem_address[log2(BURST_LEN*4) +: log2(DEPTH_LINES)].
  - Upper bits alias (wrap modulo DEPTH_LINES).
- Coherence: a read issued after a write burst completes returns the written data; there is no read-during-write overlap by construction.
- mem_rdata outside read beats holds its last value.

Optional Feature:
- Macro BURST_MEM_PROTOCOL_CHECK_EN.
- When defined, err is set and held until rst on any of:
  - mem_read and mem_write both high at IDLE acceptance;
  - mem_address low log2(BURST_LEN*4) bits nonzero at acceptance;
  - the latched request line dropping during WAIT;
  - mem_read/mem_write high during DONE.
- The transaction itself proceeds unchanged.
- When not defined: err tied to 0, no checker logic.

Test Plan:
- Preload line 3 beats 0..7 = 0x3000_0000+k; read addr 0x60 with LATENCY=4 -> mem_resp rises exactly 4 cycles after accept, 8 beats 0x30000000..0x30000007, then 1 low cycle.
- Write addr 0x40, wdata 0xA5A5_0000+k, be=4'hF; read addr 0x40 -> returns 0xA5A50000..0xA5A50007.
- Line holds 0xFFFFFFFF; write beat 2 with wdata 0x12345678, be=4'b0101, other beats be=0 -> readback beat 2 = 0xFF34FF78, others unchanged.
- Assert rst during beat 3 of a write -> mem_resp=0, busy=0 next cycle; readback shows beats 0-2 new, 3-7 old.
- mem_read and mem_write high together at 0x20 -> read burst is served, no array change. With BURST_MEM_PROTOCOL_CHECK_EN defined, err=1 and sticky until rst.
- DEPTH_LINES=256: write 0x2000 (aliases line 0), read 0x0 -> returns written data.

Source files
------------

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - line-burst memory responder with programmable access latency
// Optional protocol checker enabled by defining BURST_MEM_PROTOCOL_CHECK_EN.
module burst_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LINES = 256,
  parameter int BURST_LEN   = 8,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_byte_enable,
  output logic [31:0]           mem_rdata,
  output logic                  mem_resp,
  output logic                  busy,
  output logic                  err
);

  localparam int OFF_W  = $clog2(BURST_LEN * 4);
  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MEM_W  = IDX_W + BEAT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait;
  logic [BEAT_W-1:0]   r_beat;
  logic [IDX_W-1:0]    r_line;
  logic                r_is_read;
  logic                r_resp;
  logic                r_busy;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [DEPTH_LINES*BURST_LEN];

  logic [IDX_W-1:0]    w_line;
  logic [MEM_W-1:0]    w_cur_idx;
  logic [MEM_W-1:0]    w_next_idx;
  logic [MEM_W-1:0]    w_first_idx;
  logic                w_wr_en;
  logic                w_unused;

  assign w_line      = mem_address[OFF_W +: IDX_W];
  assign w_cur_idx   = {r_line, r_beat};
  assign w_next_idx  = {r_line, BEAT_W'(r_beat + 1'b1)};
  assign w_first_idx = {r_line, {BEAT_W{1'b0}}};
  // Gating with rst keeps an aborting beat from landing in the array.
  assign w_wr_en     = (r_state == S_BURST) && !r_is_read && !rst;
  assign w_unused    = ^mem_address;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b]) r_mem[w_cur_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_beat    <= '0;
      r_line    <= '0;
      r_is_read <= 1'b0;
      r_resp    <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            r_line    <= w_line;
            r_is_read <= mem_read;
            r_wait    <= WAIT_W'(LATENCY - 1);
            r_busy    <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait == '0) begin
            r_state <= S_BURST;
            r_resp  <= 1'b1;
            r_beat  <= '0;
            if (r_is_read) r_rdata <= r_mem[w_first_idx];
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_BURST: begin
          if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
            r_state <= S_DONE;
            r_resp  <= 1'b0;
          end else begin
            r_beat <= r_beat + 1'b1;
            if (r_is_read) r_rdata <= r_mem[w_next_idx];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_resp  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rdata = r_rdata;
  assign mem_resp  = r_resp;
  assign busy      = r_busy;

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  logic r_err;
  logic w_viol;

  assign w_viol = ((r_state == S_IDLE) && mem_read && mem_write) ||
                  ((r_state == S_IDLE) && (mem_read || mem_write) &&
                   (mem_address[OFF_W-1:0] != '0)) ||
                  ((r_state == S_WAIT) && (r_is_read ? !mem_read : !mem_write)) ||
                  ((r_state == S_DONE) && (mem_read || mem_write));

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (w_viol) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
